// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit pipelined CPU.
//   - Datapath and register-index widths
//   - Opcodes that the memory stage decodes
//   - State encoding of the memory-stage handshake FSM
package cpu_pkg;

    localparam int DATA_W = 16;
    localparam int TGT_W  = 3;

    localparam logic [2:0] OP_SW  = 3'b100;
    localparam logic [2:0] OP_LW  = 3'b101;
    localparam logic [2:0] OP_BEQ = 3'b110;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } mem_state_t;

    // True for the opcodes that need a data-memory transaction.
    function automatic logic is_memop(input logic [2:0] op);
        return (op == OP_SW) || (op == OP_LW);
    endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Request timeout counter for the memory stage.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   halt        global freeze; count holds when high
//   clear       synchronous clear (wins over enable)
//   enable      count up by one per cycle
//   hit         high while count == TIMEOUT-1
module mem_timeout_ctr #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic halt,
    input  logic clear,
    input  logic enable,
    output logic hit
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count;

    // NOTE: sequential state is written with non-blocking assignments only,
    // so every flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (!halt) begin
            if (clear) begin
                count <= '0;
            end else if (enable && !hit) begin
                // Saturates at the hit value; the FSM leaves REQ on that cycle.
                count <= count + CW'(1);
            end
        end
    end

    assign hit = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_stage.sv
// Memory stage of the 16-bit pipelined CPU, between execute and writeback.
// lw/sw are issued to data memory over a level req/ack handshake while the
// upstream stages are stalled; every other opcode passes through in one cycle.
// Ports:
//   clk, rst_n                 clock and asynchronous active-low reset
//   halt                       global freeze of all state
//   bubble_in, tgt_in,
//   opcode_in, alu_result_in,
//   store_data_in              instruction slot from execute
//   stall_out                  upstream must hold its outputs this cycle
//   mem_req/we/addr/wdata      registered request to data memory
//   mem_ack, mem_rdata         memory completion and read data
//   bubble_out, tgt_out,
//   opcode_out, alu_result_out,
//   mem_result_out             registered slot to writeback
//   bus_err                    sticky: a request timed out
module mem_access_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W  = cpu_pkg::DATA_W,
    parameter int TGT_W   = cpu_pkg::TGT_W,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              halt,
    input  logic              bubble_in,
    input  logic [TGT_W-1:0]  tgt_in,
    input  logic [2:0]        opcode_in,
    input  logic [DATA_W-1:0] alu_result_in,
    input  logic [DATA_W-1:0] store_data_in,
    output logic              stall_out,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              bubble_out,
    output logic [TGT_W-1:0]  tgt_out,
    output logic [2:0]        opcode_out,
    output logic [DATA_W-1:0] alu_result_out,
    output logic [DATA_W-1:0] mem_result_out,
    output logic              bus_err
);

    mem_state_t state;
    logic       start;
    logic       tmo_hit;
    logic       waiting;

    // NOTE: every signal driven from always_comb gets a default first,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        start     = 1'b0;
        waiting   = 1'b0;
        stall_out = 1'b0;
        if (state == IDLE) begin
            start = is_memop(opcode_in) && !bubble_in;
        end else begin
            // On the completing cycle (ack or timeout) upstream may advance.
            waiting = !mem_ack && !tmo_hit;
        end
        stall_out = !halt && (start || waiting);
    end

    mem_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .halt   (halt),
        .clear  (start),
        .enable (state == REQ),
        .hit    (tmo_hit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            mem_req        <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            bubble_out     <= 1'b1;
            tgt_out        <= '0;
            opcode_out     <= '0;
            alu_result_out <= '0;
            mem_result_out <= '0;
            bus_err        <= 1'b0;
        end else if (!halt) begin
            if (state == IDLE) begin
                if (start) begin
                    state      <= REQ;
                    mem_req    <= 1'b1;
                    mem_we     <= (opcode_in == OP_SW);
                    mem_addr   <= alu_result_in;
                    mem_wdata  <= store_data_in;
                    bubble_out <= 1'b1;
                end else begin
                    bubble_out     <= bubble_in;
                    tgt_out        <= tgt_in;
                    opcode_out     <= opcode_in;
                    alu_result_out <= alu_result_in;
                    mem_result_out <= '0;
                end
            end else if (mem_ack || tmo_hit) begin
                // Inputs still hold the lw/sw thanks to the stall.
                state          <= IDLE;
                mem_req        <= 1'b0;
                bubble_out     <= 1'b0;
                tgt_out        <= tgt_in;
                opcode_out     <= opcode_in;
                alu_result_out <= alu_result_in;
                // An ack in the timeout cycle wins over the timeout.
                if (mem_ack) begin
                    mem_result_out <= mem_we ? '0 : mem_rdata;
                end else begin
                    mem_result_out <= '0;
                    bus_err        <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage, built with TIMEOUT=4 so
// the timeout path is short; a lw acked on its fourth REQ cycle also covers
// the ack-and-timeout-in-the-same-cycle case.
module tb_mem_access_stage;

    localparam int DW = 16;
    localparam int TW = 3;

    logic          clk = 1'b0;
    logic          rst_n, halt, bubble_in, mem_ack;
    logic [TW-1:0] tgt_in;
    logic [2:0]    opcode_in;
    logic [DW-1:0] alu_result_in, store_data_in, mem_rdata;
    logic          stall_out, mem_req, mem_we, bubble_out, bus_err;
    logic [DW-1:0] mem_addr, mem_wdata, alu_result_out, mem_result_out;
    logic [TW-1:0] tgt_out;
    logic [2:0]    opcode_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_access_stage #(
        .DATA_W  (DW),
        .TGT_W   (TW),
        .TIMEOUT (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .halt           (halt),
        .bubble_in      (bubble_in),
        .tgt_in         (tgt_in),
        .opcode_in      (opcode_in),
        .alu_result_in  (alu_result_in),
        .store_data_in  (store_data_in),
        .stall_out      (stall_out),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata),
        .bubble_out     (bubble_out),
        .tgt_out        (tgt_out),
        .opcode_out     (opcode_out),
        .alu_result_out (alu_result_out),
        .mem_result_out (mem_result_out),
        .bus_err        (bus_err)
    );

    // Registered outputs are settled 2 time units after the rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic b, input logic [TW-1:0] t, input logic [2:0] op,
                         input logic [DW-1:0] alu, input logic [DW-1:0] sd);
        bubble_in     = b;
        tgt_in        = t;
        opcode_in     = op;
        alu_result_in = alu;
        store_data_in = sd;
        #1;
    endtask

    task automatic go_idle();
        mem_ack   = 1'b0;
        mem_rdata = '0;
        drive(1'b1, '0, 3'b000, '0, '0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        halt  = 1'b0;
        go_idle();
        tick();
        tick();
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b expected 0", mem_req); end
        checks++; if (bubble_out !== 1'b1) begin errors++; $display("FAIL reset_bubble: got %b expected 1", bubble_out); end
        checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL reset_bus_err: got %b expected 0", bus_err); end
        checks++; if ({tgt_out, opcode_out, alu_result_out, mem_result_out, mem_addr, mem_wdata, mem_we} !== '0) begin
            errors++; $display("FAIL reset_outputs: got nonzero data outputs, expected all 0"); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_passthrough();
        drive(1'b0, 3'd3, 3'b000, 16'h1234, 16'h0000);
        checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL add_stall: got %b expected 0", stall_out); end
        tick();
        checks++; if (tgt_out !== 3'd3) begin errors++; $display("FAIL add_tgt: got %0d expected 3", tgt_out); end
        checks++; if (alu_result_out !== 16'h1234) begin errors++; $display("FAIL add_alu: got %h expected 1234", alu_result_out); end
        checks++; if (bubble_out !== 1'b0) begin errors++; $display("FAIL add_bubble: got %b expected 0", bubble_out); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL add_mem_req: got %b expected 0", mem_req); end
        go_idle();
        tick();
    endtask

    task automatic test_lw_wait();
        int stalls = 0;
        drive(1'b0, 3'd5, 3'b101, 16'h0040, 16'h0000);
        for (int c = 0; c < 4; c++) begin
            if (stall_out === 1'b1) stalls++;
            tick();
            checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'h0040 || bubble_out !== 1'b1) begin
                errors++; $display("FAIL lw_req_c%0d: got req=%b we=%b addr=%h bub=%b expected 1 0 0040 1",
                                   c, mem_req, mem_we, mem_addr, bubble_out); end
        end
        checks++; if (stalls !== 4) begin errors++; $display("FAIL lw_stall_cycles: got %0d expected 4", stalls); end
        mem_ack   = 1'b1;
        mem_rdata = 16'hBEEF;
        #1;
        checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL lw_ack_stall: got %b expected 0", stall_out); end
        tick();
        checks++; if (mem_result_out !== 16'hBEEF) begin errors++; $display("FAIL lw_result: got %h expected beef", mem_result_out); end
        checks++; if (bubble_out !== 1'b0 || tgt_out !== 3'd5 || opcode_out !== 3'b101) begin
            errors++; $display("FAIL lw_slot: got bub=%b tgt=%0d op=%b expected 0 5 101", bubble_out, tgt_out, opcode_out); end
        checks++; if (mem_req !== 1'b0 || bus_err !== 1'b0) begin
            errors++; $display("FAIL lw_done: got req=%b err=%b expected 0 0", mem_req, bus_err); end
        go_idle();
        tick();
        checks++; if (bubble_out !== 1'b1) begin errors++; $display("FAIL lw_one_cycle: got bubble %b expected 1", bubble_out); end
    endtask

    task automatic test_sw_fast();
        drive(1'b0, 3'd2, 3'b100, 16'h0010, 16'h5A5A);
        tick();
        checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 16'h0010 || mem_wdata !== 16'h5A5A) begin
            errors++; $display("FAIL sw_req: got req=%b we=%b addr=%h data=%h expected 1 1 0010 5a5a",
                               mem_req, mem_we, mem_addr, mem_wdata); end
        mem_ack   = 1'b1;
        mem_rdata = 16'hFFFF;
        #1;
        checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL sw_ack_stall: got %b expected 0", stall_out); end
        tick();
        checks++; if (bubble_out !== 1'b0 || mem_result_out !== 16'h0000 || opcode_out !== 3'b100) begin
            errors++; $display("FAIL sw_done: got bub=%b res=%h op=%b expected 0 0000 100",
                               bubble_out, mem_result_out, opcode_out); end
        go_idle();
        tick();
    endtask

    task automatic test_back_to_back();
        drive(1'b0, 3'd1, 3'b101, 16'h0100, 16'h0000);
        tick();
        mem_ack   = 1'b1;
        mem_rdata = 16'h1111;
        tick();
        checks++; if (mem_result_out !== 16'h1111 || tgt_out !== 3'd1 || bubble_out !== 1'b0) begin
            errors++; $display("FAIL b2b_first: got res=%h tgt=%0d bub=%b expected 1111 1 0",
                               mem_result_out, tgt_out, bubble_out); end
        mem_ack = 1'b0;
        drive(1'b0, 3'd4, 3'b101, 16'h0200, 16'h0000);
        checks++; if (mem_req !== 1'b0 || stall_out !== 1'b1) begin
            errors++; $display("FAIL b2b_gap: got req=%b stall=%b expected 0 1", mem_req, stall_out); end
        tick();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0200 || bubble_out !== 1'b1) begin
            errors++; $display("FAIL b2b_second_req: got req=%b addr=%h bub=%b expected 1 0200 1",
                               mem_req, mem_addr, bubble_out); end
        mem_ack   = 1'b1;
        mem_rdata = 16'h2222;
        tick();
        checks++; if (mem_result_out !== 16'h2222 || tgt_out !== 3'd4 || bubble_out !== 1'b0) begin
            errors++; $display("FAIL b2b_second: got res=%h tgt=%0d bub=%b expected 2222 4 0",
                               mem_result_out, tgt_out, bubble_out); end
        go_idle();
        tick();
    endtask

    task automatic test_timeout_and_reset();
        drive(1'b0, 3'd7, 3'b101, 16'h0300, 16'h0000);
        tick();
        tick();
        tick();
        checks++; if (stall_out !== 1'b1) begin errors++; $display("FAIL tmo_third_stall: got %b expected 1", stall_out); end
        tick();
        checks++; if (stall_out !== 1'b0 || mem_req !== 1'b1) begin
            errors++; $display("FAIL tmo_fourth: got stall=%b req=%b expected 0 1", stall_out, mem_req); end
        tick();
        checks++; if (bus_err !== 1'b1 || mem_result_out !== 16'h0000 || bubble_out !== 1'b0 || mem_req !== 1'b0) begin
            errors++; $display("FAIL tmo_done: got err=%b res=%h bub=%b req=%b expected 1 0000 0 0",
                               bus_err, mem_result_out, bubble_out, mem_req); end
        drive(1'b0, 3'd6, 3'b101, 16'h0400, 16'h0000);
        checks++; if (stall_out !== 1'b1) begin errors++; $display("FAIL tmo_back_idle: got stall %b expected 1", stall_out); end
        tick();
        checks++; if (mem_req !== 1'b1 || bus_err !== 1'b1) begin
            errors++; $display("FAIL tmo_sticky: got req=%b err=%b expected 1 1", mem_req, bus_err); end
        rst_n = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0 || bubble_out !== 1'b1 || bus_err !== 1'b0) begin
            errors++; $display("FAIL async_reset: got req=%b bub=%b err=%b expected 0 1 0", mem_req, bubble_out, bus_err); end
        go_idle();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_halt();
        drive(1'b0, 3'd6, 3'b101, 16'h0500, 16'h0000);
        tick();
        mem_ack   = 1'b1;
        mem_rdata = 16'hCAFE;
        halt      = 1'b1;
        #1;
        checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL halt_stall: got %b expected 0", stall_out); end
        for (int c = 0; c < 5; c++) tick();
        checks++; if (mem_req !== 1'b1 || bubble_out !== 1'b1 || mem_result_out !== 16'h0000 || tgt_out !== 3'd0) begin
            errors++; $display("FAIL halt_frozen: got req=%b bub=%b res=%h tgt=%0d expected 1 1 0000 0",
                               mem_req, bubble_out, mem_result_out, tgt_out); end
        halt = 1'b0;
        tick();
        checks++; if (mem_result_out !== 16'hCAFE || bubble_out !== 1'b0 || tgt_out !== 3'd6 || mem_req !== 1'b0) begin
            errors++; $display("FAIL halt_release: got res=%h bub=%b tgt=%0d req=%b expected cafe 0 6 0",
                               mem_result_out, bubble_out, tgt_out, mem_req); end
        go_idle();
        tick();
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_lw_wait();
        test_sw_fast();
        test_back_to_back();
        test_timeout_and_reset();
        test_halt();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
